// File: rtl/dds_sweep_ctrl_if.sv
// Sweep controller bus: configuration port, start/abort controls and the DDS-facing outputs.
// Latency: none, this is wiring only.
// Backpressure: cfg_valid/cfg_ready handshake; the controller holds cfg_ready low while a sweep runs.
// Ports: master = config/control side (drives cfg_*, start, abort);
//        slave  = sweep controller (drives cfg_ready, K, P, busy, done, step_idx).
interface dds_sweep_ctrl_if #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int NW = 16
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [KW-1:0] cfg_k_start;
  logic [KW-1:0] cfg_k_step;
  logic [NW-1:0] cfg_n_steps;
  logic [NW-1:0] cfg_dwell;
  logic [PW-1:0] cfg_phase;
  logic          cfg_repeat;
  logic          start;
  logic          abort;
  logic [KW-1:0] K;
  logic [PW-1:0] P;
  logic          busy;
  logic          done;
  logic [NW-1:0] step_idx;

  modport master (
    output cfg_valid, cfg_k_start, cfg_k_step, cfg_n_steps, cfg_dwell,
           cfg_phase, cfg_repeat, start, abort,
    input  cfg_ready, K, P, busy, done, step_idx
  );

  modport slave (
    input  cfg_valid, cfg_k_start, cfg_k_step, cfg_n_steps, cfg_dwell,
           cfg_phase, cfg_repeat, start, abort,
    output cfg_ready, K, P, busy, done, step_idx
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the DDS tuning word K and phase offset P.
// Latency: start/abort take effect on the outputs one cycle after they are sampled.
// Backpressure: cfg_ready = ~busy; configuration offered during a sweep is not taken.
// Ports: clk, rst (async, active high); bus (slave modport) carries config handshake,
//        start/abort pulses and the registered K, P, busy, done, step_idx outputs.
module dds_sweep_ctrl #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int NW = 16
) (
  input  logic             clk,
  input  logic             rst,
  dds_sweep_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q;

  // Stored configuration
  logic [KW-1:0] k_start_q;
  logic [KW-1:0] k_step_q;
  logic [NW-1:0] n_steps_q;
  logic [NW-1:0] dwell_q;
  logic [PW-1:0] phase_q;
  logic          repeat_q;

  // Registered outputs and sweep progress
  logic [KW-1:0] k_q;
  logic [PW-1:0] p_q;
  logic          busy_q;
  logic          done_q;
  logic [NW-1:0] step_idx_q;
  logic [NW-1:0] dwell_cnt_q;

  logic          cfg_take;
  logic [KW-1:0] k_start_d;
  logic [NW-1:0] n_steps_d;
  logic [PW-1:0] phase_d;
  logic [NW-1:0] dwell_last;
  logic          dwell_tc;
  logic          last_step;

  // busy_q is high exactly in RUN, so it doubles as the "not IDLE" qualifier.
  assign cfg_take = bus.cfg_valid & ~busy_q;

  // A config accepted in the same cycle as start must be the one the sweep uses,
  // so the start path looks through the capture mux instead of the stored copy.
  assign k_start_d = cfg_take ? bus.cfg_k_start : k_start_q;
  assign n_steps_d = cfg_take ? bus.cfg_n_steps : n_steps_q;
  assign phase_d   = cfg_take ? bus.cfg_phase   : phase_q;

  // A dwell of 0 behaves as 1: terminal count is then 0 as well.
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - NW'(1);
  assign dwell_tc   = (dwell_cnt_q == dwell_last);
  // Only evaluated in RUN, where n_steps_q is never 0.
  assign last_step  = (step_idx_q == n_steps_q - NW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_start_q   <= '0;
      k_step_q    <= '0;
      n_steps_q   <= '0;
      dwell_q     <= '0;
      phase_q     <= '0;
      repeat_q    <= 1'b0;
      k_q         <= '0;
      p_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_idx_q  <= '0;
      dwell_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;

      if (cfg_take) begin
        k_start_q <= bus.cfg_k_start;
        k_step_q  <= bus.cfg_k_step;
        n_steps_q <= bus.cfg_n_steps;
        dwell_q   <= bus.cfg_dwell;
        phase_q   <= bus.cfg_phase;
        repeat_q  <= bus.cfg_repeat;
      end

      case (state_q)
        IDLE: begin
          // abort beats start; K/P are left alone so the DDS keeps its tone.
          if (bus.start && !bus.abort) begin
            if (n_steps_d != '0) begin
              state_q     <= RUN;
              busy_q      <= 1'b1;
              k_q         <= k_start_d;
              p_q         <= phase_d;
              step_idx_q  <= '0;
              dwell_cnt_q <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (dwell_tc) begin
            dwell_cnt_q <= '0;
            if (!last_step) begin
              k_q        <= k_q + k_step_q;
              step_idx_q <= step_idx_q + NW'(1);
            end else if (repeat_q) begin
              k_q        <= k_start_q;
              step_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q + NW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = ~busy_q;
  assign bus.K         = k_q;
  assign bus.P         = p_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_idx  = step_idx_q;

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer that drives the tuning word `K` and phase offset `P` inputs of the DDS phase accumulator. It holds a sweep configuration loaded over a valid/ready port, then steps `K` linearly from a start word by a fixed increment. Each step is held for a programmable number of clock cycles, and the sweep runs once or repeats. It sits between the register/config logic and the DDS core and is the only writer of the core's `K`/`P` inputs.

## Interface
- `KW`, 32, tuning-word width (matches DDS `K`)
- `PW`, 11, phase-offset width (matches DDS `P`)
- `NW`, 16, width of step count, dwell count and step index

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration accepted when `cfg_valid & cfg_ready`; equals `~busy`
- `cfg_k_start`  in  KW  first tuning word
- `cfg_k_step`  in  KW  increment per step, unsigned, modulo 2^KW
- `cfg_n_steps`  in  NW  number of steps in one sweep; 0 means empty sweep
- `cfg_dwell`  in  NW  cycles per step; 0 is treated as 1
- `cfg_phase`  in  PW  phase offset driven on `P` for the whole sweep
- `cfg_repeat`  in  1  1 restarts from `cfg_k_start` after the last step
- `start`  in  1  single-cycle pulse that starts a sweep
- `abort`  in  1  single-cycle pulse that stops a sweep
- `K`  out  KW  registered tuning word to the DDS
- `P`  out  PW  registered phase offset to the DDS
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse when a non-repeating sweep completes
- `step_idx`  out  NW  index of the current step, 0-based

## Operation
- Reset values: `K`=0, `P`=0, `busy`=0, `done`=0, `step_idx`=0, `cfg_ready`=1, state IDLE, all stored config registers 0.
- There are two states, IDLE and RUN.
- Config capture:
  - Config is captured only in IDLE, on `cfg_valid & cfg_ready`.
  - While in RUN, `cfg_valid` is ignored and the stored config is unchanged.
- IDLE to RUN:
  - The transition happens on `start` when the stored `n_steps` is not 0.
  - If `cfg_valid` and `start` occur in the same cycle, the newly captured config is the one used.
  - On `start` with `n_steps`=0: stay in IDLE, pulse `done` once, leave `K`/`P` unchanged.
- Entering RUN loads `K`←`k_start`, `P`←`phase`, `step_idx`←0, and clears the dwell counter.
- In RUN, the dwell counter counts 0..max(dwell,1)−1. At the terminal count:
  - If `step_idx` < `n_steps`−1: `K`←`K`+`k_step` (wraps modulo 2^KW, no saturation) and `step_idx`+1.
  - If `step_idx` = `n_steps`−1 and `repeat`=1: `K`←`k_start`, `step_idx`←0, no `done`.
  - If `step_idx` = `n_steps`−1 and `repeat`=0: go to IDLE, `busy`←0, pulse `done`.
- `abort` in RUN: go to IDLE the next cycle with no `done`. `abort` has priority over the terminal-count actions in the same cycle.
- `abort` in IDLE is ignored. If `abort` and `start` occur in the same IDLE cycle, `abort` wins and the sweep does not start.
- `start` while in RUN is ignored.
- In IDLE, after completion or abort, `K` and `P` hold their last values so the DDS keeps its output frequency.
- `busy` is high exactly while in RUN.

## Timing
- `start` sampled at edge t: `busy`=1, `K`=`k_start`, `P`=`phase` and `step_idx`=0 are all visible after edge t (cycle t+1).
- Step i (0-based) is visible from cycle t+1+i·D to t+(i+1)·D, where D = max(dwell,1).
- Non-repeating sweep: `busy` falls and `done`=1 in cycle t+1+N·D, where N = `n_steps`. `done` lasts exactly one cycle.
- Repeat wrap: `K` returns to `k_start` in cycle t+1+N·D and continues with the same period.
- `abort` sampled at edge a: `busy`=0 in cycle a+1; `K` keeps the value it had in cycle a.
- `cfg_ready` is low from the cycle after `start` until the cycle `busy` falls.
- After a completion or abort, a new config or `start` is accepted from the first cycle in which `busy`=0.

## Test plan
- Reset asserted mid-RUN (`rst` pulse): `K`=0, `P`=0, `busy`=0, `done`=0 immediately, without waiting for a clock edge; after release, `cfg_ready`=1.
- Config k_start=0x1000, k_step=0x100, n_steps=4, dwell=3, phase=0x155, repeat=0, then `start`: `K` = 0x1000, 0x1100, 0x1200, 0x1300, each for 3 cycles; `P`=0x155 throughout; `done` one cycle after the last step; `K` stays 0x1300 afterwards.
- k_start=0xFFFFFF00, k_step=0x200, n_steps=2, dwell=0: `K` = 0xFFFFFF00, then 0x00000100 (wrap), one cycle each; then `done`.
- repeat=1, n_steps=3, dwell=2: `K` cycles start, start+step, start+2·step with period 6 and no `done`. `abort` mid-step: `busy`=0 the next cycle, `K` held, `done` stays 0.
- `start` with n_steps=0: single `done` pulse, `busy` stays 0, `K` unchanged.
- Same-cycle events, checked separately:
  - `cfg_valid` and `start` in IDLE: the new k_start appears on `K`.
  - `abort` and `start` in IDLE: no sweep starts.
  - `start` or `cfg_valid` during RUN: no effect on the sweep or the stored config.
